key_press_detector: RTL

- Producer end of the `key_num`/`note_ready` interface that the piano display and sound paths consume.
- Watches the camera/video pixel stream in XVGA timing (`hcount`/`vcount`/`vsync`) inside a horizontal detection band split into 17 equal-width key zones.
- Counts bright marker pixels per zone each frame; at frame end it serially evaluates every zone with frame-to-frame debounce.
- Publishes a registered `key_num` vector plus a one-cycle `note_ready` strobe once per frame.

---
 rtl/piano_pkg.sv | 11 +
 rtl/key_column_tracker.sv | 43 ++++
 rtl/key_press_detector.sv | 135 +++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared piano constants and types used by the key detector and the display/sound consumers.
package piano_pkg;
    localparam int NUM_KEYS = 17;
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int HCOUNT_W = $clog2(SCREEN_W) + 1;
    localparam int VCOUNT_W = $clog2(SCREEN_H);

    typedef logic [4:0] key_idx_t;
    typedef enum logic [1:0] {ACCUM, EVAL, PUBLISH} frame_state_t;
endpackage

// File: rtl/key_column_tracker.sv
// Incremental column-to-zone mapper: follows hcount and reports the zone index of the
// previous cycle's column, avoiding a divider on the pixel path.
module key_column_tracker
    import piano_pkg::*;
#(
    parameter int KEY_WIDTH = 60,
    parameter int X_START   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HCOUNT_W-1:0] hcount,
    output key_idx_t            zone_idx,
    output logic                in_x_band
);
    localparam int                   SUB_W     = $clog2(KEY_WIDTH);
    localparam logic [HCOUNT_W-1:0]  X_LO      = HCOUNT_W'(X_START);
    localparam logic [HCOUNT_W-1:0]  X_HI      = HCOUNT_W'(X_START + NUM_KEYS * KEY_WIDTH);
    localparam logic [SUB_W-1:0]     SUB_LAST  = SUB_W'(KEY_WIDTH - 1);
    localparam key_idx_t             LAST_ZONE = key_idx_t'(NUM_KEYS - 1);

    logic [SUB_W-1:0] sub_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_cnt   <= '0;
            zone_idx  <= '0;
            in_x_band <= 1'b0;
        end else begin
            in_x_band <= (hcount >= X_LO) && (hcount < X_HI);
            if (hcount == X_LO) begin
                sub_cnt  <= '0;
                zone_idx <= '0;
            end else if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                // Past the last zone the index parks; the x-compare masks those columns.
                if (zone_idx != LAST_ZONE)
                    zone_idx <= zone_idx + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_press_detector.sv
// Counts bright marker pixels per key zone each frame, debounces the per-zone hit across
// frames, and publishes key_num with a note_ready strobe. Chords need KEY_DETECT_MULTI_KEY_EN.
module key_press_detector
    import piano_pkg::*;
#(
    parameter int         KEY_WIDTH     = 60,
    parameter int         X_START       = 2,
    parameter int         Y_TOP         = 600,
    parameter int         Y_BOTTOM      = 700,
    parameter logic [7:0] LUMA_THRESH   = 8'd200,
    parameter int         CNT_W         = 12,
    parameter int         HIT_THRESH    = 32,
    parameter int         FRAMES_STABLE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [VCOUNT_W-1:0] vcount,
    input  logic                vsync,
    input  logic                blank,
    input  logic [7:0]          luma,
    output logic [NUM_KEYS-1:0] key_num,
    output logic                note_ready
);
    localparam logic [VCOUNT_W-1:0] Y_LO      = VCOUNT_W'(Y_TOP);
    localparam logic [VCOUNT_W-1:0] Y_HI      = VCOUNT_W'(Y_BOTTOM);
    localparam logic [CNT_W-1:0]    HIT_MIN   = CNT_W'(HIT_THRESH);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [2:0]          DEB_LIMIT = 3'(FRAMES_STABLE);
    localparam key_idx_t            LAST_ZONE = key_idx_t'(NUM_KEYS - 1);

    frame_state_t state, state_nxt;
    key_idx_t     zone_idx, eval_idx;
    logic         in_x_band;
    logic [VCOUNT_W-1:0] vcount_d;
    logic         blank_d, vsync_prev;
    logic [7:0]   luma_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt;
    logic [NUM_KEYS-1:0][2:0]       deb;
    logic [NUM_KEYS-1:0]            stable, key_nxt;
    logic         vsync_fall, pix_hit, zone_hit, ready_nxt;

    key_column_tracker #(.KEY_WIDTH(KEY_WIDTH), .X_START(X_START)) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .zone_idx  (zone_idx),
        .in_x_band (in_x_band)
    );

    // Align pixel attributes with the tracker's registered zone index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcount_d   <= '0;
            blank_d    <= 1'b1;
            luma_d     <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vcount_d   <= vcount;
            blank_d    <= blank;
            luma_d     <= luma;
            vsync_prev <= vsync;
        end
    end

    assign vsync_fall = vsync_prev & ~vsync;
    assign pix_hit    = in_x_band && !blank_d && (vcount_d >= Y_LO) && (vcount_d <= Y_HI)
                        && (luma_d >= LUMA_THRESH);
    assign zone_hit   = cnt[eval_idx] >= HIT_MIN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (vsync_fall) state_nxt = EVAL;
            EVAL:    if (eval_idx == LAST_ZONE) state_nxt = PUBLISH;
            PUBLISH: state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eval_idx <= '0;
            cnt      <= '0;
            deb      <= '0;
            stable   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    eval_idx <= '0;
                    if (pix_hit && cnt[zone_idx] != CNT_MAX)
                        cnt[zone_idx] <= cnt[zone_idx] + 1'b1;
                end
                EVAL: begin
                    eval_idx      <= eval_idx + 1'b1;
                    cnt[eval_idx] <= '0;
                    if (zone_hit == stable[eval_idx]) begin
                        deb[eval_idx] <= '0;
                    end else if (deb[eval_idx] + 3'd1 == DEB_LIMIT) begin
                        stable[eval_idx] <= ~stable[eval_idx];
                        deb[eval_idx]    <= '0;
                    end else begin
                        deb[eval_idx] <= deb[eval_idx] + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_nxt = (state == PUBLISH);
`ifdef KEY_DETECT_MULTI_KEY_EN
        key_nxt = stable;
`else
        // Isolate the lowest set bit for single-voice playback.
        key_nxt = stable & (~stable + 1'b1);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_num    <= '0;
            note_ready <= 1'b0;
        end else begin
            note_ready <= ready_nxt;
            if (ready_nxt) key_num <= key_nxt;
        end
    end
endmodule
